// File: rtl/mips_pipe_pkg.sv
// Shared defaults and encodings for the MIPS pipeline hazard logic.
package mips_pipe_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/mips_hazard_scoreboard_if.sv
// Decode/forwarding/commit signal bundle between the pipeline and the hazard scoreboard.
interface mips_hazard_scoreboard_if
  import mips_pipe_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
);

  logic [NUM_RD*ADDR_W-1:0]  rd_addr;
  logic [NUM_RD-1:0]         rd_used;
  logic [NUM_RD*DATA_W-1:0]  rf_rdata;
  logic [NUM_RD*DATA_W-1:0]  hd_rdata;

  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_wen;
  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_hi_we;
  logic [NUM_FWD-1:0]        fwd_lo_we;
  logic [NUM_FWD*DATA_W-1:0] fwd_hi;
  logic [NUM_FWD*DATA_W-1:0] fwd_lo;

  logic                      hilo_used;
  logic [DATA_W-1:0]         hd_hi;
  logic [DATA_W-1:0]         hd_lo;
  logic                      wb_hi_we;
  logic                      wb_lo_we;
  logic [DATA_W-1:0]         wb_hi;
  logic [DATA_W-1:0]         wb_lo;

  logic                      md_start;
  logic                      md_is_div;
  logic                      md_flush;
  logic                      md_done;
  logic                      hd_wait;
  logic [31:0]               stall_cnt;

  modport master (
    output rd_addr, rd_used, rf_rdata,
    output fwd_valid, fwd_wen, fwd_waddr, fwd_ready, fwd_data,
    output fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
    output hilo_used, wb_hi_we, wb_lo_we, wb_hi, wb_lo,
    output md_start, md_is_div, md_flush,
    input  hd_rdata, hd_hi, hd_lo, md_done, hd_wait, stall_cnt
  );

  modport slave (
    input  rd_addr, rd_used, rf_rdata,
    input  fwd_valid, fwd_wen, fwd_waddr, fwd_ready, fwd_data,
    input  fwd_hi_we, fwd_lo_we, fwd_hi, fwd_lo,
    input  hilo_used, wb_hi_we, wb_lo_we, wb_hi, wb_lo,
    input  md_start, md_is_div, md_flush,
    output hd_rdata, hd_hi, hd_lo, md_done, hd_wait, stall_cnt
  );

endinterface

// File: rtl/mips_md_sequencer.sv
// Mult/div latency sequencer: counts the op's latency and pulses md_done when the EX result is valid.
module mips_md_sequencer
  import mips_pipe_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic md_is_div,
  input  logic md_flush,
  output logic md_done,
  output logic md_wait
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] lat_m1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The accept cycle already consumes one count, so BUSY starts at lat-2 and ends at 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    md_done = 1'b0;
    lat_m1  = md_is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    if (md_flush || rst) begin
      state_n = MD_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            if (lat_m1 == '0) begin
              md_done = 1'b1;
            end else begin
              state_n = MD_BUSY;
              cnt_n   = lat_m1 - CNT_W'(1);
            end
          end
        end
        MD_BUSY: begin
          if (cnt == '0) begin
            md_done = 1'b1;
            state_n = MD_IDLE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: begin
          state_n = MD_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign md_wait = md_start & ~md_done;

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Decode-stage hazard unit: GPR and HI/LO forwarding, decode stall, committed HI/LO and stall counter.
module mips_hazard_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  mips_hazard_scoreboard_if.slave  bus
);

  logic [NUM_RD-1:0] raw_stall;
  logic [DATA_W-1:0] hi_reg, lo_reg;
  logic [31:0]       stall_cnt_q;
  logic              md_done_raw, md_wait;

  mips_md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .md_start  (bus.md_start),
    .md_is_div (bus.md_is_div),
    .md_flush  (bus.md_flush),
    .md_done   (md_done_raw),
    .md_wait   (md_wait)
  );

  // Stages are scanned far-to-near so the nearest matching stage overwrites the selection.
  always_comb begin
    logic              hit;
    logic              rdy;
    logic [DATA_W-1:0] sel;
    bus.hd_rdata = '0;
    raw_stall    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      hit = 1'b0;
      rdy = 1'b1;
      sel = bus.rf_rdata[i*DATA_W +: DATA_W];
      for (int s = NUM_FWD - 1; s >= 0; s--) begin
        if (bus.fwd_valid[s] && bus.fwd_wen[s] &&
            (bus.fwd_waddr[s*ADDR_W +: ADDR_W] == bus.rd_addr[i*ADDR_W +: ADDR_W])) begin
          hit = 1'b1;
          rdy = bus.fwd_ready[s];
          sel = bus.fwd_data[s*DATA_W +: DATA_W];
        end
      end
      if (bus.rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
        hit = 1'b0;
        sel = '0;
      end
      bus.hd_rdata[i*DATA_W +: DATA_W] = sel;
      raw_stall[i] = bus.rd_used[i] & hit & ~rdy;
    end
  end

  always_comb begin
    bus.hd_hi = hi_reg;
    bus.hd_lo = lo_reg;
    for (int s = NUM_FWD - 1; s >= 0; s--) begin
      if (bus.fwd_valid[s] && bus.fwd_hi_we[s]) bus.hd_hi = bus.fwd_hi[s*DATA_W +: DATA_W];
      if (bus.fwd_valid[s] && bus.fwd_lo_we[s]) bus.hd_lo = bus.fwd_lo[s*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (bus.wb_hi_we) hi_reg <= bus.wb_hi;
      if (bus.wb_lo_we) lo_reg <= bus.wb_lo;
    end
  end

  assign bus.md_done = ~rst & md_done_raw;
  assign bus.hd_wait = ~rst & ((|raw_stall) | md_wait | (bus.hilo_used & md_wait));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus.hd_wait && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed bench for mips_hazard_scoreboard: forwarding priority, stalls, mult/div sequencing, HI/LO.
module tb_mips_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_hazard_scoreboard_if bus ();

  mips_hazard_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rd_addr   = '0;
    bus.rd_used   = '0;
    bus.rf_rdata  = '0;
    bus.fwd_valid = '0;
    bus.fwd_wen   = '0;
    bus.fwd_waddr = '0;
    bus.fwd_ready = '0;
    bus.fwd_data  = '0;
    bus.fwd_hi_we = '0;
    bus.fwd_lo_we = '0;
    bus.fwd_hi    = '0;
    bus.fwd_lo    = '0;
    bus.hilo_used = 1'b0;
    bus.wb_hi_we  = 1'b0;
    bus.wb_lo_we  = 1'b0;
    bus.wb_hi     = '0;
    bus.wb_lo     = '0;
    bus.md_start  = 1'b0;
    bus.md_is_div = 1'b0;
    bus.md_flush  = 1'b0;
  endtask

  task automatic set_stage(input int s, input logic v, input logic [4:0] a,
                           input logic r, input logic [31:0] d);
    bus.fwd_valid[s]         = v;
    bus.fwd_wen[s]           = 1'b1;
    bus.fwd_waddr[s*5 +: 5]  = a;
    bus.fwd_ready[s]         = r;
    bus.fwd_data[s*32 +: 32] = d;
  endtask

  initial begin
    clear_inputs();
    // Reset with pending mult and a load-use hazard: outputs held low
    rst = 1'b1;
    bus.md_start = 1'b1;
    bus.rd_addr[4:0] = 5'd9;
    bus.rd_used = 2'b01;
    set_stage(0, 1'b1, 5'd9, 1'b0, 32'h0);
    #1;
    chk("rst_wait", 32'(bus.hd_wait), 32'd0);
    chk("rst_done", 32'(bus.md_done), 32'd0);
    tick();
    tick();
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_hd_hi", bus.hd_hi, 32'd0);
    chk("rst_hd_lo", bus.hd_lo, 32'd0);
    rst = 1'b0;
    clear_inputs();

    // Nearest of two matching stages wins
    bus.rd_addr[4:0] = 5'd8;
    bus.rd_addr[9:5] = 5'd0;
    bus.rd_used = 2'b11;
    bus.rf_rdata[31:0]  = 32'hDEAD;
    bus.rf_rdata[63:32] = 32'h5555;
    set_stage(0, 1'b1, 5'd8, 1'b1, 32'h11);
    set_stage(2, 1'b1, 5'd8, 1'b1, 32'h33);
    #1;
    chk("fwd_near", bus.hd_rdata[31:0], 32'h11);
    chk("fwd_near_wait", 32'(bus.hd_wait), 32'd0);
    chk("port1_r0", bus.hd_rdata[63:32], 32'h0);
    bus.fwd_valid[0] = 1'b0;
    #1;
    chk("fwd_far", bus.hd_rdata[31:0], 32'h33);
    bus.fwd_valid[2] = 1'b0;
    #1;
    chk("fwd_rf", bus.hd_rdata[31:0], 32'hDEAD);
    tick();
    clear_inputs();

    // Load-use stall on port 0
    bus.rd_addr[4:0] = 5'd9;
    bus.rd_used = 2'b01;
    set_stage(0, 1'b1, 5'd9, 1'b0, 32'h99);
    #1;
    chk("load_wait", 32'(bus.hd_wait), 32'd1);
    tick();
    chk("load_stall_cnt", bus.stall_cnt, 32'd1);
    bus.rd_used = 2'b00;
    #1;
    chk("unused_wait", 32'(bus.hd_wait), 32'd0);
    tick();
    chk("unused_stall_cnt", bus.stall_cnt, 32'd1);
    // Near not-ready stalls even though a farther stage is ready
    bus.rd_used = 2'b01;
    set_stage(2, 1'b1, 5'd9, 1'b1, 32'h77);
    #1;
    chk("near_notready_wait", 32'(bus.hd_wait), 32'd1);
    chk("near_notready_data", bus.hd_rdata[31:0], 32'h99);
    tick();
    chk("near_notready_cnt", bus.stall_cnt, 32'd2);
    clear_inputs();

    // r0 is never forwarded and never stalls; port 1 forwards independently
    bus.rd_addr[4:0] = 5'd0;
    bus.rd_addr[9:5] = 5'd10;
    bus.rd_used = 2'b11;
    set_stage(0, 1'b1, 5'd0, 1'b0, 32'hFFFF);
    set_stage(1, 1'b1, 5'd10, 1'b1, 32'h77);
    #1;
    chk("r0_data", bus.hd_rdata[31:0], 32'h0);
    chk("r0_wait", 32'(bus.hd_wait), 32'd0);
    chk("port1_fwd", bus.hd_rdata[63:32], 32'h77);
    tick();
    clear_inputs();

    // Multiply, latency 4
    bus.md_start = 1'b1;
    bus.md_is_div = 1'b0;
    #1;
    for (int k = 1; k <= 4; k++) begin
      chk("mul_done", 32'(bus.md_done), 32'(k == 4));
      chk("mul_wait", 32'(bus.hd_wait), 32'(k != 4));
      tick();
    end
    bus.md_start = 1'b0;
    #1;
    chk("mul_idle_done", 32'(bus.md_done), 32'd0);
    chk("mul_idle_wait", 32'(bus.hd_wait), 32'd0);
    chk("mul_stall_cnt", bus.stall_cnt, 32'd5);
    tick();

    // Divide, latency 32
    bus.md_start = 1'b1;
    bus.md_is_div = 1'b1;
    #1;
    for (int k = 1; k <= 32; k++) begin
      chk("div_done", 32'(bus.md_done), 32'(k == 32));
      chk("div_wait", 32'(bus.hd_wait), 32'(k != 32));
      tick();
    end
    clear_inputs();
    #1;
    chk("div_idle_done", 32'(bus.md_done), 32'd0);
    chk("div_stall_cnt", bus.stall_cnt, 32'd36);
    tick();

    // Flush in BUSY cycle 2 aborts without md_done
    bus.md_start = 1'b1;
    #1;
    chk("flush_c1_wait", 32'(bus.hd_wait), 32'd1);
    tick();
    bus.md_flush = 1'b1;
    #1;
    chk("flush_c2_done", 32'(bus.md_done), 32'd0);
    tick();
    clear_inputs();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("flush_no_done", 32'(bus.md_done), 32'd0);
      tick();
    end
    chk("flush_stall_cnt", bus.stall_cnt, 32'd38);

    // Flush and start together from IDLE: flush wins
    bus.md_start = 1'b1;
    bus.md_flush = 1'b1;
    #1;
    chk("flush_start_done", 32'(bus.md_done), 32'd0);
    tick();
    clear_inputs();
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("flush_start_no_done", 32'(bus.md_done), 32'd0);
      tick();
    end
    chk("flush_start_cnt", bus.stall_cnt, 32'd39);

    // Reset mid-BUSY aborts and clears the counter
    bus.wb_hi_we = 1'b1;
    bus.wb_hi = 32'h5151;
    bus.md_start = 1'b1;
    tick();
    bus.wb_hi_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstbusy_done", 32'(bus.md_done), 32'd0);
    chk("rstbusy_wait", 32'(bus.hd_wait), 32'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("rstbusy_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rstbusy_hi", bus.hd_hi, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("rstbusy_no_done", 32'(bus.md_done), 32'd0);
      tick();
    end

    // HI/LO commit and forwarding
    bus.wb_hi_we = 1'b1;
    bus.wb_hi = 32'hABCD;
    bus.hilo_used = 1'b1;
    #1;
    chk("hi_same_cycle", bus.hd_hi, 32'h0);
    tick();
    bus.wb_hi_we = 1'b0;
    #1;
    chk("hi_committed", bus.hd_hi, 32'hABCD);
    bus.wb_lo_we = 1'b1;
    bus.wb_lo = 32'h5A5A;
    bus.fwd_valid[0] = 1'b1;
    bus.fwd_lo_we[0] = 1'b1;
    bus.fwd_lo[31:0] = 32'h4242;
    #1;
    chk("lo_fwd", bus.hd_lo, 32'h4242);
    tick();
    clear_inputs();
    bus.hilo_used = 1'b1;
    #1;
    chk("lo_committed", bus.hd_lo, 32'h5A5A);
    bus.fwd_valid[1] = 1'b1;
    bus.fwd_hi_we[1] = 1'b1;
    bus.fwd_hi[63:32] = 32'h1234;
    #1;
    chk("hi_fwd_s1", bus.hd_hi, 32'h1234);
    bus.fwd_valid[2] = 1'b1;
    bus.fwd_hi_we[2] = 1'b1;
    bus.fwd_hi[95:64] = 32'h9999;
    #1;
    chk("hi_fwd_near", bus.hd_hi, 32'h1234);
    bus.fwd_valid[1] = 1'b0;
    #1;
    chk("hi_fwd_s2", bus.hd_hi, 32'h9999);
    chk("hilo_no_wait", 32'(bus.hd_wait), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
